// File: rtl/comparator_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
// The xyz encoding is one-hot: x = greater, y = equal, z = less.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } comparator_state_t;

    localparam logic [2:0] XYZ_NONE = 3'b000;
    localparam logic [2:0] XYZ_GT   = 3'b100;
    localparam logic [2:0] XYZ_EQ   = 3'b010;
    localparam logic [2:0] XYZ_LT   = 3'b001;

    // Index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/comparator_bit_step.sv
// One step of the MSB-first comparison: decides the result from a single bit
// pair, inverting the sense of the decision on a two's-complement sign bit.
module comparator_bit_step
    import comparator_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       sign_bit,
    input  logic       last_bit,
    output logic       decided,
    output logic [2:0] result
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        decided = 1'b0;
        result  = XYZ_NONE;
        if (a_bit != b_bit) begin
            decided = 1'b1;
            // A set sign bit means negative, so the operand holding 1 is the smaller one.
            if (a_bit ^ sign_bit)
                result = XYZ_GT;
            else
                result = XYZ_LT;
        end else if (last_bit) begin
            decided = 1'b1;
            result  = XYZ_EQ;
        end
    end

endmodule

// File: rtl/comparator_serial.sv
// Bit-serial WIDTH-bit comparator with early termination on the first
// differing bit and a start/busy/done handshake.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       xyz
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    comparator_state_t state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              signed_q;
    logic [IDX_W-1:0]  idx;

    logic              step_decided;
    logic [2:0]        step_result;
    logic              sign_bit;
    logic              last_bit;

    assign sign_bit = signed_q && (idx == IDX_MSB);
    assign last_bit = (idx == '0);

    comparator_bit_step u_step (
        .a_bit    (a_q[idx]),
        .b_bit    (b_q[idx]),
        .sign_bit (sign_bit),
        .last_bit (last_bit),
        .decided  (step_decided),
        .result   (step_result)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            xyz      <= XYZ_NONE;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A start in the DONE cycle chains straight into the next comparison.
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        idx      <= IDX_MSB;
                        state    <= COMPARE;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (step_decided) begin
                        xyz   <= step_result;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial: the driver pushes expected result and
// done-cycle per accepted start; a monitor pops and compares on every done pulse.
module tb_comparator_serial;

    localparam int W = 8;

    typedef struct {
        logic [2:0] xyz;
        int         cyc;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [2:0]   xyz;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;
    exp_t sb[$];

    comparator_serial #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .xyz         (xyz)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer comparison of the operands as numbers.
    function automatic logic [2:0] ref_xyz(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int ix;
        int iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        if (ix > iy) return 3'b100;
        if (ix < iy) return 3'b001;
        return 3'b010;
    endfunction

    // Edges to result: WIDTH minus the index of the top differing bit, or WIDTH if equal.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return W - i;
        return W;
    endfunction

    always @(negedge clock) begin
        if (reset === 1'b0 && done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(xyz), 32'hxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_xyz", 32'(xyz), 32'(e.xyz));
                check("result_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge with the block accepting; returns at the next negedge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        start       = 1'b1;
        a           = x;
        b           = y;
        signed_mode = s;
        @(posedge clock);
        #1;
        e.xyz = ref_xyz(x, y, s);
        e.cyc = cyc + ref_lat(x, y);
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        check("result_timeout", sb.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        int busy_cnt;
        int d0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_xyz", 32'(xyz), 0);
        reset = 1'b0;
        @(negedge clock);

        // Equal operands: full-length compare, result holds afterwards.
        issue(8'h35, 8'h35, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            busy_cnt++;
            @(negedge clock);
            #1;
        end
        check("eq_busy_cycles", busy_cnt, 8);
        wait_result();
        repeat (2) @(negedge clock);
        check("eq_xyz_held", 32'(xyz), 32'b010);

        // Sign-bit difference flips with mode.
        issue(8'h80, 8'h7F, 1'b0);
        wait_result();
        issue(8'h80, 8'h7F, 1'b1);
        wait_result();

        // Difference only in the LSB.
        issue(8'h12, 8'h13, 1'b0);
        wait_result();
        issue(8'hFE, 8'hFF, 1'b1);
        wait_result();

        // Start while busy is ignored.
        d0 = done_seen;
        issue(8'h40, 8'h41, 1'b0);
        @(negedge clock);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clock);
        start = 1'b0;
        wait_result();
        repeat (3) @(negedge clock);
        check("busy_start_ignored_dones", done_seen - d0, 1);

        // Reset in the 4th cycle of a comparison abandons it.
        issue(8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_done", 32'(done), 0);
        check("midreset_xyz", 32'(xyz), 0);
        sb.delete();
        reset = 1'b0;
        @(negedge clock);
        issue(8'h01, 8'h00, 1'b0);
        wait_result();

        // Back-to-back: start held in the DONE cycle.
        d0 = done_seen;
        issue(8'h90, 8'h10, 1'b0);
        @(negedge clock);
        check("b2b_done_cycle", 32'(done), 1);
        issue(8'h00, 8'h00, 1'b0);
        check("b2b_no_idle_busy", 32'(busy), 1);
        wait_result();
        repeat (2) @(negedge clock);
        check("b2b_dones", done_seen - d0, 2);

        // Randomised: half the cases differ in a single chosen bit.
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(1, 0) == 1)
                rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
            else
                rb = W'($urandom);
            issue(ra, rb, rs);
            wait_result();
        end

        check("final_queue_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
